multicore_sync_fproc_sim: RTL and testbench

Simulation-side hub for multi-core processor benches. It generalises the single-core loopback of sync-barrier and fproc handshakes to NUM_CORES cores. It implements a real barrier: release happens only when every participating core has arrived. It also serves a round-robin fproc responder with a host-loadable result table and a fixed response latency. It sits between the NUM_CORES proc instances and the bench.

---
 rtl/multicore_sync_fproc_sim.sv | 136 +++++++++++++
 tb/tb_multicore_sync_fproc_sim.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicore_sync_fproc_sim.sv
// multicore_sync_fproc_sim: multi-core barrier hub plus round-robin fproc responder with a host-loaded result table
module multicore_sync_fproc_sim #(
  parameter int NUM_CORES = 4,
  parameter int SYNC_BARRIER_WIDTH = 8,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FPROC_LATENCY = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CORES-1:0]                    core_mask,
  input  logic [NUM_CORES-1:0]                    sync_enable,
  input  logic [NUM_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier,
  output logic [NUM_CORES-1:0]                    sync_ready,
  input  logic [NUM_CORES-1:0]                    fproc_enable,
  input  logic [NUM_CORES*FPROC_ID_WIDTH-1:0]     fproc_id,
  output logic [NUM_CORES-1:0]                    fproc_ready,
  output logic [NUM_CORES*DATA_WIDTH-1:0]         fproc_data,
  input  logic                                    tbl_we,
  input  logic [FPROC_ID_WIDTH-1:0]               tbl_addr,
  input  logic [DATA_WIDTH-1:0]                   tbl_wdata,
  output logic                                    sync_err,
  output logic                                    fproc_err
);
  localparam int CW = $clog2(NUM_CORES);
  localparam int SW = SYNC_BARRIER_WIDTH;
  localparam int IW = FPROC_ID_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int L = FPROC_LATENCY;
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, RELEASE = 2'd2;
  logic [1:0] state;
  logic [NUM_CORES-1:0] mask, arrived, eff_mask, arr_next;
  logic [SW-1:0] bid, first_id, eff_id;
  logic mm, s_err;
  // In IDLE the live core_mask and the lowest arriving core's id act as the barrier's mask and id
  always_comb begin
    first_id = '0;
    for (int i = NUM_CORES-1; i >= 0; i--)
      if (sync_enable[i]) first_id = sync_barrier[i*SW +: SW];
    eff_mask = (state == IDLE) ? core_mask : mask;
    eff_id = (state == IDLE) ? first_id : bid;
    mm = 1'b0;
    for (int i = 0; i < NUM_CORES; i++)
      if (sync_enable[i] && eff_mask[i] && !arrived[i] && sync_barrier[i*SW +: SW] != eff_id) mm = 1'b1;
    arr_next = arrived | (sync_enable & eff_mask);
    s_err = (state == RELEASE) ? |sync_enable : ((|(sync_enable & ~eff_mask)) || (|(sync_enable & arrived)) || mm);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      arrived <= '0;
      mask <= '0;
      bid <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= sync_err || s_err;
      if (state == IDLE && |sync_enable && |core_mask) begin
        mask <= core_mask;
        bid <= first_id;
        arrived <= arr_next;
        state <= ((arr_next & core_mask) == core_mask) ? RELEASE : COLLECT;
      end else if (state == COLLECT) begin
        arrived <= arr_next;
        if ((arr_next & mask) == mask) state <= RELEASE;
      end else if (state == RELEASE) begin
        arrived <= '0;
        state <= IDLE;
      end
    end
  end
  assign sync_ready = (state == RELEASE) ? mask : '0;
  logic [NUM_CORES-1:0] pend, busy, acc, elig, gnt_hot;
  logic [IW-1:0] id_q [NUM_CORES];
  logic [CW-1:0] ptr, gnt, cand;
  logic gnt_v;
  logic [IW-1:0] gid;
  logic [DW-1:0] tbl [2**IW];
  logic pv [L];
  logic [CW-1:0] pc [L];
  logic [DW-1:0] pd [L];
  // A core stays busy from grant until its response cycle, so requests in that window are dropped
  always_comb begin
    busy = '0;
    for (int s = 0; s < L; s++)
      if (pv[s]) busy[pc[s]] = 1'b1;
    acc = fproc_enable & ~pend & ~busy;
    elig = pend | acc;
    gnt_v = 1'b0;
    gnt = '0;
    cand = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = CW'((int'(ptr) + k) % NUM_CORES);
      if (!gnt_v && elig[cand]) begin
        gnt_v = 1'b1;
        gnt = cand;
      end
    end
    gnt_hot = gnt_v ? (NUM_CORES'(1) << gnt) : '0;
    gid = acc[gnt] ? fproc_id[int'(gnt)*IW +: IW] : id_q[gnt];
  end
  always_ff @(posedge clk)
    if (tbl_we) tbl[tbl_addr] <= tbl_wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      ptr <= '0;
      fproc_err <= 1'b0;
      for (int s = 0; s < L; s++) pv[s] <= 1'b0;
    end else begin
      pend <= elig & ~gnt_hot;
      fproc_err <= fproc_err || (|(fproc_enable & (pend | busy)));
      if (gnt_v) ptr <= (int'(gnt) == NUM_CORES-1) ? '0 : gnt + 1'b1;
      pv[0] <= gnt_v;
      for (int s = 1; s < L; s++) pv[s] <= pv[s-1];
    end
  end
  // Table read shares the edge with any write, so a colliding grant sees the old entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++)
      if (acc[i]) id_q[i] <= fproc_id[i*IW +: IW];
    pc[0] <= gnt;
    pd[0] <= tbl[gid];
    for (int s = 1; s < L; s++) begin
      pc[s] <= pc[s-1];
      pd[s] <= pd[s-1];
    end
  end
  always_comb begin
    fproc_ready = '0;
    fproc_data = '0;
    if (pv[L-1]) begin
      fproc_ready[pc[L-1]] = 1'b1;
      fproc_data[int'(pc[L-1])*DW +: DW] = pd[L-1];
    end
  end
endmodule

// File: tb/tb_multicore_sync_fproc_sim.sv
// tb_multicore_sync_fproc_sim: directed stimulus, per-cycle compare against a schedule-based model, plus literal checks
module tb_multicore_sync_fproc_sim;
  localparam int N = 4, SW = 8, IW = 8, DW = 32, L = 4, DEPTH = 256;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] core_mask, sync_enable, sync_ready, fproc_enable, fproc_ready;
  logic [N*SW-1:0] sync_barrier;
  logic [N*IW-1:0] fproc_id;
  logic [N*DW-1:0] fproc_data;
  logic tbl_we, sync_err, fproc_err;
  logic [IW-1:0] tbl_addr;
  logic [DW-1:0] tbl_wdata;
  always #5 clk = ~clk;
  multicore_sync_fproc_sim #(.NUM_CORES(N), .SYNC_BARRIER_WIDTH(SW), .FPROC_ID_WIDTH(IW),
    .DATA_WIDTH(DW), .FPROC_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .core_mask(core_mask), .sync_enable(sync_enable),
    .sync_barrier(sync_barrier), .sync_ready(sync_ready), .fproc_enable(fproc_enable),
    .fproc_id(fproc_id), .fproc_ready(fproc_ready), .fproc_data(fproc_data),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .sync_err(sync_err), .fproc_err(fproc_err));
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  // Expected outputs are scheduled by absolute cycle number
  logic [N-1:0] exp_sr [DEPTH];
  logic [N-1:0] exp_fr [DEPTH];
  logic [N*DW-1:0] exp_fd [DEPTH];
  logic [DW-1:0] tm [256];
  bit m_active, m_serr, m_ferr, granted;
  logic [N-1:0] m_mask, m_arr, m_pend;
  logic [SW-1:0] m_id;
  logic [IW-1:0] m_pid [N];
  int m_resp [N];
  int m_ptr, g;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic model_step();
    int c;
    c = cyc;
    if (reset) begin
      m_active = 0; m_arr = '0; m_serr = 0; m_ferr = 0; m_pend = '0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_resp[i] = -1;
      for (int k = c + 1; k < DEPTH; k++) begin
        exp_sr[k] = '0; exp_fr[k] = '0; exp_fd[k] = '0;
      end
    end else begin
      if (exp_sr[c] != '0) begin
        if (sync_enable != '0) m_serr = 1;
      end else if (sync_enable != '0) begin
        if (!m_active) begin
          if (core_mask == '0) m_serr = 1;
          else begin
            m_active = 1; m_mask = core_mask; m_arr = '0;
            for (int i = N-1; i >= 0; i--) if (sync_enable[i]) m_id = sync_barrier[i*SW +: SW];
          end
        end
        if (m_active) begin
          for (int i = 0; i < N; i++)
            if (sync_enable[i]) begin
              if (!m_mask[i] || m_arr[i]) m_serr = 1;
              else begin
                if (sync_barrier[i*SW +: SW] != m_id) m_serr = 1;
                m_arr[i] = 1'b1;
              end
            end
          if ((m_arr & m_mask) == m_mask) begin
            if (c + 1 < DEPTH) exp_sr[c+1] = m_mask;
            m_active = 0; m_arr = '0;
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (fproc_enable[i]) begin
          if (m_pend[i] || m_resp[i] >= c) m_ferr = 1;
          else begin m_pend[i] = 1'b1; m_pid[i] = fproc_id[i*IW +: IW]; end
        end
      granted = 0;
      for (int k = 0; k < N; k++) begin
        g = (m_ptr + k) % N;
        if (!granted && m_pend[g]) begin
          granted = 1; m_pend[g] = 1'b0; m_resp[g] = c + L;
          if (c + L < DEPTH) begin
            exp_fr[c+L][g] = 1'b1;
            exp_fd[c+L][g*DW +: DW] = tm[m_pid[g]];
          end
          m_ptr = (g + 1) % N;
        end
      end
    end
    if (tbl_we) tm[tbl_addr] = tbl_wdata;
  endtask
  always @(posedge clk) begin
    model_step();
    cyc++;
  end
  always @(negedge clk)
    if (cyc >= 1 && cyc < DEPTH) begin
      check("sync_ready", sync_ready, exp_sr[cyc]);
      check("fproc_ready", fproc_ready, exp_fr[cyc]);
      check("fproc_data", fproc_data, exp_fd[cyc]);
      check("sync_err", sync_err, m_serr);
      check("fproc_err", fproc_err, m_ferr);
    end
  task automatic go(input int c);
    while (cyc < c) begin
      @(negedge clk);
      sync_enable = '0; fproc_enable = '0; tbl_we = 1'b0;
    end
  endtask
  initial begin
    for (int k = 0; k < DEPTH; k++) begin exp_sr[k] = '0; exp_fr[k] = '0; exp_fd[k] = '0; end
    for (int k = 0; k < 256; k++) tm[k] = '0;
    for (int i = 0; i < N; i++) begin m_resp[i] = -1; m_pid[i] = '0; end
    m_id = '0; m_mask = '0;
    reset = 1'b1; core_mask = '0; sync_enable = '0; sync_barrier = '0;
    fproc_enable = '0; fproc_id = '0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    go(3); reset = 1'b0;
    check("rst_sync_ready", sync_ready, 4'h0); check("rst_fproc_ready", fproc_ready, 4'h0);
    check("rst_errs", {sync_err, fproc_err}, 2'b00);
    tbl_we = 1'b1; tbl_addr = 8'h10; tbl_wdata = 32'hDEADBEEF;
    go(4); tbl_we = 1'b1; tbl_addr = 8'h11; tbl_wdata = 32'h12345678;
    go(5); tbl_we = 1'b1; tbl_addr = 8'h20; tbl_wdata = 32'h0BADF00D;
    go(10); core_mask = 4'hF; sync_barrier = {4{8'd5}}; sync_enable = 4'b0101;
    go(12); sync_enable = 4'b0010;
    go(15); check("bar_early", sync_ready, 4'h0); sync_enable = 4'b1000;
    go(16); check("bar_release", sync_ready, 4'hF);
    go(17); check("bar_one_cycle", sync_ready, 4'h0); check("bar_no_err", sync_err, 1'b0);
    go(20); fproc_id = {8'h11, 8'h11, 8'h10, 8'h10}; fproc_enable = 4'hF;
    go(23); check("rr_early", fproc_ready, 4'h0);
    go(24); check("rr_c0", fproc_ready, 4'b0001); check("rr_d0", fproc_data, {96'h0, 32'hDEADBEEF});
    go(25); check("rr_c1", fproc_ready, 4'b0010); check("rr_d1", fproc_data, {64'h0, 32'hDEADBEEF, 32'h0});
    go(26); check("rr_c2", fproc_ready, 4'b0100); check("rr_d2", fproc_data, {32'h0, 32'h12345678, 64'h0});
    go(27); check("rr_c3", fproc_ready, 4'b1000); check("rr_d3", fproc_data, {32'h12345678, 96'h0});
    go(28); check("rr_no_err", fproc_err, 1'b0);
    go(30); core_mask = 4'b0101; sync_barrier = {4{8'd3}}; sync_enable = 4'b0111;
    go(31); check("partial_rel", sync_ready, 4'b0101); check("partial_err", sync_err, 1'b1);
    go(32); check("partial_done", sync_ready, 4'h0);
    go(33); reset = 1'b1;
    go(34); reset = 1'b0; check("err_cleared", sync_err, 1'b0);
    go(36); core_mask = 4'hF; sync_barrier = {4{8'd7}}; sync_enable = 4'b0001;
    go(37); sync_barrier[15:8] = 8'd8; sync_enable = 4'b0010;
    go(38); sync_barrier[15:8] = 8'd7; check("mismatch_err", sync_err, 1'b1); sync_enable = 4'b0001;
    go(39); check("dup_no_rel", sync_ready, 4'h0); sync_enable = 4'b1100;
    go(40); check("dup_rel", sync_ready, 4'hF);
    go(42); reset = 1'b1;
    go(43); reset = 1'b0;
    go(45); fproc_enable = 4'b0010;
    go(47); fproc_enable = 4'b0010;
    go(48); check("overlap_err", fproc_err, 1'b1);
    go(49); check("overlap_rsp", fproc_ready, 4'b0010); check("overlap_d", fproc_data, {64'h0, 32'hDEADBEEF, 32'h0});
    go(53); check("overlap_single", fproc_ready, 4'h0);
    go(57); fproc_id = {8'h20, 8'h20, 8'h10, 8'h10}; fproc_enable = 4'b0100;
    tbl_we = 1'b1; tbl_addr = 8'h20; tbl_wdata = 32'hAAAA5555;
    go(61); check("coll_old", fproc_data, {32'h0, 32'h0BADF00D, 64'h0});
    go(63); fproc_enable = 4'b1000;
    go(67); check("coll_new", fproc_data, {32'hAAAA5555, 96'h0});
    go(70); fproc_enable = 4'b0001; sync_barrier = {4{8'd1}}; sync_enable = 4'b0111;
    go(72); reset = 1'b1;
    go(73); reset = 1'b0;
    go(74); check("rst_no_rsp", fproc_ready, 4'h0);
    go(76); sync_barrier = {4{8'd2}}; sync_enable = 4'b1000;
    go(77); check("rst_fresh_bar", sync_ready, 4'h0);
    go(78); sync_enable = 4'b0111;
    go(79); check("rst_bar_rel", sync_ready, 4'hF);
    go(80); fproc_enable = 4'b0001;
    go(84); check("tbl_kept", fproc_data, {96'h0, 32'hDEADBEEF});
    go(85); reset = 1'b1;
    go(86); reset = 1'b0; core_mask = 4'b0010; sync_enable = 4'b0010;
    go(87); check("single_rel", sync_ready, 4'b0010); sync_enable = 4'b0100;
    go(88); check("rel_arrival_err", sync_err, 1'b1);
    go(90); core_mask = 4'hF; sync_enable = 4'b1011;
    go(91); check("rel_arrival_ignored", sync_ready, 4'h0);
    go(92); sync_enable = 4'b0100;
    go(93); check("after_rel_bar", sync_ready, 4'hF);
    go(95); reset = 1'b1;
    go(96); reset = 1'b0;
    go(97); core_mask = 4'h0; sync_enable = 4'b0001;
    go(98); check("mask0_err", sync_err, 1'b1); check("mask0_idle", sync_ready, 4'h0);
    core_mask = 4'b0001;
    go(99); sync_enable = 4'b0001;
    go(100); check("mask0_then_rel", sync_ready, 4'b0001);
    go(104);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
